uart_tx_frame_arbiter: RTL and testbench

Shares the single UART transmitter between `NUM_CH` byte-stream requesters (diagnostic channels). It picks one requester per frame, round-robin, and wraps that requester's payload in a frame. Each frame is a sync byte, a channel-ID byte, the payload bytes, and an XOR checksum. The block sits between the diagnostic sources and `UARTTxModule`, driving that module's `send_input`/`valid` and consuming its `ready`.

---
 rtl/uart_frame_pkg.sv | 8 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/uart_tx_frame_arbiter.sv | 76 +++++++
 tb/tb_uart_tx_frame_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/uart_frame_pkg.sv
// uart_frame_pkg: frame FSM states, default sync byte and checksum helper for the UART frame arbiter
package uart_frame_pkg;
  typedef enum logic [2:0] {IDLE, SYNC, ID, PAYLOAD, CSUM} frame_state_t;
  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;
  function automatic logic [7:0] xor8(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority grant whose search starts just after the previous winner
module rr_arbiter #(
  parameter int NUM_CH = 4,
  localparam int AW = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req,
  input  logic              advance,
  output logic [NUM_CH-1:0] grant,
  output logic [AW-1:0]     idx
);
  logic [AW-1:0] last_grant, cand;
  logic hit;
  always_ff @(posedge clk)
    if (rst) last_grant <= AW'(NUM_CH - 1);
    else if (advance && hit) last_grant <= idx;
  always_comb begin
    idx = '0;
    cand = '0;
    hit = 1'b0;
    for (int k = 1; k <= NUM_CH; k++) begin
      cand = AW'((int'(last_grant) + k) % NUM_CH);
      if (!hit && req[cand]) begin
        idx = cand;
        hit = 1'b1;
      end
    end
    grant = hit ? NUM_CH'(1) << idx : '0;
  end
endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// uart_tx_frame_arbiter: round-robin framing (sync, id, payload, xor) of NUM_CH byte streams onto one UART transmitter
module uart_tx_frame_arbiter
  import uart_frame_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int MAX_LEN = 16,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  localparam int AW = $clog2(NUM_CH)
) (
  input  logic                   sample_clock,
  input  logic                   reset,
  input  logic [NUM_CH-1:0]      ch_valid,
  input  logic [NUM_CH-1:0][7:0] ch_data,
  input  logic [NUM_CH-1:0]      ch_last,
  output logic [NUM_CH-1:0]      ch_ready,
  output logic [7:0]             tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic [AW-1:0]          active_ch,
  output logic                   truncated
);
  frame_state_t state, nxt;
  logic [NUM_CH-1:0] grant;
  logic [AW-1:0] win;
  logic [7:0] csum, cnt;
  logic xfer, start, at_max, sel_last;
  rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
    .clk(sample_clock),
    .rst(reset),
    .req(ch_valid),
    .advance(state == IDLE),
    .grant(grant),
    .idx(win)
  );
  assign xfer = tx_valid && tx_ready;
  assign start = state == IDLE && |grant;
  assign at_max = cnt == 8'(MAX_LEN - 1);
  assign sel_last = ch_last[active_ch];
  always_ff @(posedge sample_clock)
    if (reset) begin
      state <= IDLE;
      active_ch <= '0;
      csum <= '0;
      cnt <= '0;
      truncated <= 1'b0;
    end else begin
      state <= nxt;
      truncated <= state == PAYLOAD && xfer && at_max && !sel_last;
      if (start) begin
        active_ch <= win;
        csum <= '0;
        cnt <= '0;
      end
      if ((state == ID || state == PAYLOAD) && xfer) csum <= xor8(csum, tx_data);
      if (state == PAYLOAD && xfer) cnt <= cnt + 8'd1;
    end
  always_comb begin
    nxt = state == IDLE ? (start ? SYNC : IDLE)
        : !xfer ? state
        : state == SYNC ? ID
        : state == ID ? PAYLOAD
        : state == PAYLOAD ? (sel_last || at_max ? CSUM : PAYLOAD)
        : IDLE;
  end
  always_comb begin
    tx_valid = state inside {SYNC, ID, CSUM} || (state == PAYLOAD && ch_valid[active_ch]);
    tx_data = state == SYNC ? SYNC_BYTE
            : state == ID ? 8'(active_ch)
            : state == PAYLOAD ? ch_data[active_ch]
            : state == CSUM ? csum
            : 8'h00;
    ch_ready = state == PAYLOAD && tx_ready ? NUM_CH'(1) << active_ch : '0;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// tb_uart_tx_frame_arbiter: cycle vectors, directed frame sequences and randomized streams against a frame-level model
module tb_uart_tx_frame_arbiter;
  localparam int NCH = 4;
  localparam int MLEN = 4;
  typedef struct packed {logic [7:0] d; logic l;} byte_t;
  typedef struct {
    logic rst; logic [3:0] cv, cl; logic [7:0] d; logic tr;
    logic tv; logic [7:0] td; logic bz; logic [3:0] cr; logic tg;
  } vec_t;
  logic sample_clock = 1'b0, reset = 1'b1, tx_ready = 1'b0;
  logic [NCH-1:0] ch_valid = '0, ch_last = '0, ch_ready;
  logic [NCH-1:0][7:0] ch_data = '0;
  logic [7:0] tx_data;
  logic tx_valid, busy, truncated;
  logic [1:0] active_ch;
  int total = 0, passed = 0;
  vec_t tbl[$];
  byte_t src[NCH][$];
  logic [7:0] expq[$], got[$];
  int exp_trunc, got_trunc, exp_act;
  always #5 sample_clock = ~sample_clock;
  uart_tx_frame_arbiter #(.NUM_CH(NCH), .MAX_LEN(MLEN), .SYNC_BYTE(8'hA5)) dut (
    .sample_clock(sample_clock), .reset(reset), .ch_valid(ch_valid), .ch_data(ch_data),
    .ch_last(ch_last), .ch_ready(ch_ready), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy), .active_ch(active_ch), .truncated(truncated)
  );
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endfunction
  task automatic add(input logic rst, input logic [3:0] cv, cl, input logic [7:0] d, input logic tr,
                     input logic tv, input logic [7:0] td, input logic bz, input logic [3:0] cr, input logic tg);
    vec_t v;
    v.rst = rst; v.cv = cv; v.cl = cl; v.d = d; v.tr = tr;
    v.tv = tv; v.td = td; v.bz = bz; v.cr = cr; v.tg = tg;
    tbl.push_back(v);
  endtask
  task automatic do_reset();
    reset = 1'b1; ch_valid = '0; ch_last = '0; ch_data = '0; tx_ready = 1'b0;
    @(negedge sample_clock);
    @(negedge sample_clock);
    reset = 1'b0;
  endtask
  task automatic model();
    byte_t q[NCH][$];
    byte_t b;
    logic [7:0] sum;
    int last = NCH - 1;
    for (int i = 0; i < NCH; i++) q[i] = src[i];
    expq.delete();
    exp_trunc = 0;
    exp_act = 0;
    while (1) begin
      int c = -1;
      for (int k = 1; k <= NCH; k++)
        if (c < 0 && q[(last + k) % NCH].size() > 0) c = (last + k) % NCH;
      if (c < 0) break;
      last = c;
      exp_act = c;
      sum = 8'(c);
      expq.push_back(8'hA5);
      expq.push_back(8'(c));
      for (int n = 0; n < MLEN; n++) begin
        b = q[c].pop_front();
        expq.push_back(b.d);
        sum ^= b.d;
        if (b.l) break;
        if (n == MLEN - 1) exp_trunc++;
      end
      expq.push_back(sum);
    end
  endtask
  function automatic bit all_empty();
    for (int i = 0; i < NCH; i++) if (src[i].size() > 0) return 1'b0;
    return 1'b1;
  endfunction
  task automatic run(input int mode);
    int cyc = 0;
    logic pend = 1'b0;
    logic [7:0] pdat = 8'h00;
    got.delete();
    got_trunc = 0;
    model();
    while (cyc < 3000 && !(got.size() >= expq.size() && !busy && all_empty())) begin
      for (int i = 0; i < NCH; i++) begin
        ch_valid[i] = src[i].size() > 0;
        ch_data[i] = ch_valid[i] ? src[i][0].d : 8'h00;
        ch_last[i] = ch_valid[i] && src[i][0].l;
      end
      tx_ready = mode == 0 ? 1'b1 : mode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
      #1;
      if (pend) chk("hold_while_stalled", {tx_valid, tx_data}, {1'b1, pdat});
      pend = tx_valid && !tx_ready;
      pdat = tx_data;
      if (tx_valid && tx_ready) got.push_back(tx_data);
      if (truncated) got_trunc++;
      if (ch_ready != '0) chk("ready_onehot", 32'($onehot0(ch_ready)), 32'd1);
      for (int i = 0; i < NCH; i++) if (ch_valid[i] && ch_ready[i]) void'(src[i].pop_front());
      @(negedge sample_clock);
      cyc++;
    end
    ch_valid = '0;
    chk("run_within_budget", 32'(cyc < 3000), 32'd1);
    chk("byte_count", got.size(), expq.size());
    for (int i = 0; i < expq.size(); i++)
      chk($sformatf("byte%0d", i), i < got.size() ? 32'(got[i]) : 32'hDEAD, 32'(expq[i]));
    chk("trunc_pulses", got_trunc, exp_trunc);
    chk("active_ch_hold", 32'(active_ch), 32'(exp_act));
  endtask
  task automatic push(input int c, input logic [7:0] d, input logic l);
    src[c].push_back('{d: d, l: l});
  endtask
  initial begin
    logic [7:0] tr_lit[12] = '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'hA5, 8'h02, 8'h05, 8'h06, 8'h01};
    logic [7:0] bp_lit[6] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'h56, 8'h70};
    add(1, 4'h0, 4'h0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 0);
    add(0, 4'h1, 4'h0, 8'h11, 1, 0, 8'h00, 0, 4'h0, 0);
    add(0, 4'h1, 4'h0, 8'h11, 1, 1, 8'hA5, 1, 4'h0, 0);
    add(0, 4'h1, 4'h0, 8'h11, 1, 1, 8'h00, 1, 4'h0, 0);
    add(0, 4'h1, 4'h0, 8'h11, 1, 1, 8'h11, 1, 4'h1, 0);
    add(0, 4'h1, 4'h1, 8'h22, 1, 1, 8'h22, 1, 4'h1, 0);
    add(0, 4'h0, 4'h0, 8'h00, 1, 1, 8'h33, 1, 4'h0, 0);
    add(0, 4'h0, 4'h0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 0);
    add(0, 4'h1, 4'h0, 8'h44, 1, 0, 8'h00, 0, 4'h0, 0);
    add(0, 4'h1, 4'h0, 8'h44, 1, 1, 8'hA5, 1, 4'h0, 0);
    add(0, 4'h1, 4'h0, 8'h44, 0, 1, 8'h00, 1, 4'h0, 0);
    add(0, 4'h1, 4'h0, 8'h44, 1, 1, 8'h00, 1, 4'h0, 0);
    add(1, 4'h1, 4'h0, 8'h44, 0, 1, 8'h44, 1, 4'h0, 0);
    add(0, 4'h1, 4'h0, 8'h44, 1, 0, 8'h00, 0, 4'h0, 0);
    add(0, 4'h1, 4'h0, 8'h44, 1, 1, 8'hA5, 1, 4'h0, 0);
    add(0, 4'h1, 4'h0, 8'h55, 1, 1, 8'h00, 1, 4'h0, 0);
    add(0, 4'h1, 4'h0, 8'h55, 1, 1, 8'h55, 1, 4'h1, 0);
    for (int i = 0; i < 5; i++) add(0, 4'h0, 4'h0, 8'h00, 1, 0, 8'h00, 1, 4'h1, 0);
    add(0, 4'h1, 4'h0, 8'h66, 1, 1, 8'h66, 1, 4'h1, 0);
    add(0, 4'h1, 4'h0, 8'h77, 1, 1, 8'h77, 1, 4'h1, 0);
    add(0, 4'h1, 4'h0, 8'h88, 1, 1, 8'h88, 1, 4'h1, 0);
    add(0, 4'h0, 4'h0, 8'h00, 1, 1, 8'hCC, 1, 4'h0, 1);
    add(0, 4'h0, 4'h0, 8'h00, 1, 0, 8'h00, 0, 4'h0, 0);
    @(negedge sample_clock);
    foreach (tbl[n]) begin
      reset = tbl[n].rst;
      ch_valid = tbl[n].cv;
      ch_last = tbl[n].cl;
      for (int i = 0; i < NCH; i++) ch_data[i] = tbl[n].d;
      tx_ready = tbl[n].tr;
      #1;
      chk($sformatf("row%0d_tx_valid", n), 32'(tx_valid), 32'(tbl[n].tv));
      chk($sformatf("row%0d_tx_data", n), 32'(tx_data), 32'(tbl[n].td));
      chk($sformatf("row%0d_busy", n), 32'(busy), 32'(tbl[n].bz));
      chk($sformatf("row%0d_ch_ready", n), 32'(ch_ready), 32'(tbl[n].cr));
      chk($sformatf("row%0d_truncated", n), 32'(truncated), 32'(tbl[n].tg));
      @(negedge sample_clock);
    end
    do_reset();
    push(1, 8'hAA, 1); push(1, 8'hBB, 1); push(3, 8'hCC, 1);
    run(0);
    chk("rr_id0", 32'(got[1]), 32'h01);
    chk("rr_id1", 32'(got[5]), 32'h03);
    chk("rr_id2", 32'(got[9]), 32'h01);
    do_reset();
    push(0, 8'h12, 0); push(0, 8'h34, 0); push(0, 8'h56, 1);
    run(1);
    for (int i = 0; i < 6; i++) chk($sformatf("bp_lit%0d", i), 32'(got[i]), 32'(bp_lit[i]));
    do_reset();
    for (int i = 1; i <= 6; i++) push(2, 8'(i), i == 6);
    run(0);
    for (int i = 0; i < 12; i++) chk($sformatf("trunc_lit%0d", i), 32'(got[i]), 32'(tr_lit[i]));
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int c = 0; c < NCH; c++) begin
        int nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) begin
          int len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) push(c, 8'($urandom_range(0, 255)), b == len - 1);
        end
      end
      run(2);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
